// File: rtl/midi_audio_pkg.sv
// Shared constants, parser state encoding and the note-to-phase-increment
// table generator used by the MIDI voice allocator and its frequency ROMs.
package midi_audio_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] PROG_CHG = 4'hC;
    localparam logic [3:0] CHAN_PRS = 4'hD;

    typedef enum logic [1:0] {
        P_IDLE,
        P_WAIT_D1,
        P_WAIT_D2,
        P_SKIP
    } parse_state_e;

    // Phase increment for a 48 kHz accumulator of width d, equal-tempered,
    // A4 (note 69) = 440 Hz. Only evaluated at elaboration time.
    function automatic logic [23:0] freq_table(input int n, input int d);
        real f;
        f = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0))
            * (2.0 ** real'(d)) / 48000.0;
        return 24'($rtoi(f + 0.5));
    endfunction

endpackage

// File: rtl/midi_note_freq_rom.sv
// Registered 128-entry note -> phase-increment ROM for one voice channel.
// Ports: clk_i, rst_ni (async low), en_i (load), note_i[6:0], freq_o[D-1:0].
module midi_note_freq_rom
    import midi_audio_pkg::*;
#(
    parameter int D = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [6:0]   note_i,
    output logic [D-1:0] freq_o
);

    logic [D-1:0] rom [128];
    logic [D-1:0] freq_q;
    logic [D-1:0] freq_d;

    for (genvar i = 0; i < 128; i++) begin : g_rom
        localparam logic [23:0] V = freq_table(i, D);
        assign rom[i] = V[D-1:0];
    end

    // Only reload while the channel is sounding so a released voice
    // keeps its last increment and an unused voice stays at zero.
    always_comb begin
        freq_d = freq_q;
        if (en_i) begin
            freq_d = rom[note_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            freq_q <= '0;
        end else begin
            freq_q <= freq_d;
        end
    end

    assign freq_o = freq_q;

endmodule

// File: rtl/midi_audio_unit.sv
// MIDI Note On/Off parser and voice allocator driving per-channel oscillators.
// Ports: iCLK, inRST (async low), iMidiRd/iMidiRe byte stream in;
// oNoteNumber/oNoteOn per channel, oAudioFreq/oAudioPlay one cycle later.
module midi_audio_unit
    import midi_audio_pkg::*;
#(
    parameter int    pChannel       = 1,
    parameter int    pAudioBitDepth = 16,
    parameter string pSim           = "no"
) (
    input  logic                               iCLK,
    input  logic                               inRST,
    input  logic [7:0]                         iMidiRd,
    input  logic                               iMidiRe,
    output logic [pChannel*pAudioBitDepth-1:0] oAudioFreq,
    output logic [pChannel-1:0]                oAudioPlay,
    output logic [pChannel*7-1:0]              oNoteNumber,
    output logic [pChannel-1:0]                oNoteOn
);

    localparam int C = pChannel;
    localparam int D = pAudioBitDepth;

    parse_state_e state_q, state_d;
    logic         is_on_q, is_on_d;
    logic [6:0]   key_q, key_d;
    logic         skip2_q, skip2_d;

    logic [6:0]   note_q [C];
    logic [6:0]   note_d [C];
    logic [C-1:0] on_q, on_d;
    logic [C-1:0] play_q;
    logic [C-1:0] match;
    logic         hit;
    logic         found;
    logic         exec;

    logic [3:0]   hi;
    logic         b_rt, b_sys, b_stat, b_data;

    assign hi     = iMidiRd[7:4];
    assign b_rt   = (iMidiRd[7:3] == 5'b11111);
    assign b_sys  = (hi == 4'hF) && !b_rt;
    assign b_stat = iMidiRd[7] && (hi != 4'hF);
    assign b_data = !iMidiRd[7];

    always_comb begin
        match = '0;
        for (int c = 0; c < C; c++) begin
            match[c] = (note_q[c] == key_q);
        end
        hit = |(match & on_q);
    end

    always_comb begin
        state_d = state_q;
        is_on_d = is_on_q;
        key_d   = key_q;
        skip2_d = skip2_q;
        exec    = 1'b0;
        if (iMidiRe) begin
            unique case (1'b1)
                b_rt: begin
                end
                b_sys: state_d = P_IDLE;
                b_stat: begin
                    unique case (hi)
                        NOTE_OFF, NOTE_ON: begin
                            state_d = P_WAIT_D1;
                            is_on_d = hi[0];
                        end
                        PROG_CHG, CHAN_PRS: begin
                            state_d = P_SKIP;
                            skip2_d = 1'b0;
                        end
                        default: begin
                            state_d = P_SKIP;
                            skip2_d = 1'b1;
                        end
                    endcase
                end
                b_data: begin
                    unique case (state_q)
                        P_WAIT_D1: begin
                            key_d   = iMidiRd[6:0];
                            state_d = P_WAIT_D2;
                        end
                        P_WAIT_D2: begin
                            exec    = 1'b1;
                            state_d = P_WAIT_D1;
                        end
                        P_SKIP: begin
                            if (skip2_q) begin
                                skip2_d = 1'b0;
                            end else begin
                                state_d = P_IDLE;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            endcase
        end
    end

    // Allocation: a held note is left alone, otherwise the lowest free
    // channel takes it. Release clears every channel holding the key.
    always_comb begin
        note_d = note_q;
        on_d   = on_q;
        found  = 1'b0;
        if (exec) begin
            if (is_on_q && (iMidiRd[6:0] != 7'd0)) begin
                if (!hit) begin
                    for (int c = 0; c < C; c++) begin
                        if (!on_q[c] && !found) begin
                            note_d[c] = key_q;
                            on_d[c]   = 1'b1;
                            found     = 1'b1;
                        end
                    end
                end
            end else begin
                on_d = on_q & ~match;
            end
        end
    end

    always_ff @(posedge iCLK or negedge inRST) begin
        if (!inRST) begin
            state_q <= P_IDLE;
            is_on_q <= 1'b0;
            key_q   <= '0;
            skip2_q <= 1'b0;
            on_q    <= '0;
            play_q  <= '0;
            for (int c = 0; c < C; c++) begin
                note_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            is_on_q <= is_on_d;
            key_q   <= key_d;
            skip2_q <= skip2_d;
            on_q    <= on_d;
            play_q  <= on_q;
            for (int c = 0; c < C; c++) begin
                note_q[c] <= note_d[c];
            end
        end
    end

    for (genvar c = 0; c < C; c++) begin : g_ch
        logic [D-1:0] freq;

        midi_note_freq_rom #(.D(D)) u_rom (
            .clk_i  (iCLK),
            .rst_ni (inRST),
            .en_i   (on_q[c]),
            .note_i (note_q[c]),
            .freq_o (freq)
        );

        assign oAudioFreq[c*D +: D]  = freq;
        assign oNoteNumber[c*7 +: 7] = note_q[c];
    end

    assign oNoteOn    = on_q;
    assign oAudioPlay = play_q;

    if (pSim == "yes") begin : g_sim
        always @(posedge iCLK) begin
            if (inRST && iMidiRe) begin
                assert (!$isunknown(iMidiRd));
            end
        end
    end

endmodule

// File: tb/tb_midi_audio_unit.sv
// Self-checking bench: 1- and 4-channel instances share one byte stream
// and are compared against a message-level reference model.
module tb_midi_audio_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rd = 8'h00;
    logic        re = 1'b0;

    logic [15:0] f1;
    logic        p1;
    logic [6:0]  n1;
    logic        o1;
    logic [63:0] f4;
    logic [3:0]  p4;
    logic [27:0] n4;
    logic [3:0]  o4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    midi_audio_unit #(.pChannel(1), .pAudioBitDepth(16)) u_dut1 (
        .iCLK(clk), .inRST(rst_n), .iMidiRd(rd), .iMidiRe(re),
        .oAudioFreq(f1), .oAudioPlay(p1), .oNoteNumber(n1), .oNoteOn(o1)
    );

    midi_audio_unit #(.pChannel(4), .pAudioBitDepth(16), .pSim("yes")) u_dut4 (
        .iCLK(clk), .inRST(rst_n), .iMidiRd(rd), .iMidiRe(re),
        .oAudioFreq(f4), .oAudioPlay(p4), .oNoteNumber(n4), .oNoteOn(o4)
    );

    // ---------------- reference model ----------------
    int rs;
    int need;
    int dbuf[$];
    int mnote[2][4];
    bit mon[2][4];
    int mfreq[2][4];
    int psz[2] = '{1, 4};

    function automatic int ref_freq(input int n);
        real f;
        f = 440.0 * $pow(2.0, real'(n - 69) / 12.0) * 65536.0 / 48000.0;
        return $rtoi(f + 0.5);
    endfunction

    function automatic void model_reset();
        rs = 0;
        need = 0;
        dbuf.delete();
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 4; c++) begin
                mnote[p][c] = 0;
                mon[p][c] = 0;
                mfreq[p][c] = 0;
            end
    endfunction

    function automatic void model_exec(input bit is_on, input int k, input int v);
        for (int p = 0; p < 2; p++) begin
            if (is_on && v != 0) begin
                bit held = 0;
                for (int c = 0; c < psz[p]; c++)
                    if (mon[p][c] && mnote[p][c] == k) held = 1;
                if (!held) begin
                    for (int c = 0; c < psz[p]; c++) begin
                        if (!mon[p][c]) begin
                            mnote[p][c] = k;
                            mon[p][c] = 1;
                            mfreq[p][c] = ref_freq(k);
                            break;
                        end
                    end
                end
            end else begin
                for (int c = 0; c < psz[p]; c++)
                    if (mnote[p][c] == k) mon[p][c] = 0;
            end
        end
    endfunction

    function automatic void model_byte(input int b);
        if (b >= 'hF8) return;
        if (b >= 'hF0) begin
            rs = 0;
            dbuf.delete();
            return;
        end
        if (b >= 'h80) begin
            rs = b >> 4;
            need = (rs == 'hC || rs == 'hD) ? 1 : 2;
            dbuf.delete();
            return;
        end
        if (rs == 0) return;
        dbuf.push_back(b);
        if (dbuf.size() == need) begin
            if (rs == 8 || rs == 9) model_exec(rs == 9, dbuf[0], dbuf[1]);
            else rs = 0;
            dbuf.delete();
        end
    endfunction

    function automatic logic [24:0] exp1();
        return {16'(mfreq[0][0]), mon[0][0], 7'(mnote[0][0]), mon[0][0]};
    endfunction

    function automatic logic [99:0] exp4();
        logic [63:0] f;
        logic [27:0] n;
        logic [3:0]  o;
        for (int c = 0; c < 4; c++) begin
            f[c*16 +: 16] = 16'(mfreq[1][c]);
            n[c*7 +: 7]   = 7'(mnote[1][c]);
            o[c]          = mon[1][c];
        end
        return {f, o, n, o};
    endfunction

    // ---------------- drivers ----------------
    task automatic send(input logic [7:0] b);
        rd = b;
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        model_byte(int'(b));
    endtask

    task automatic send_slow(input logic [7:0] b);
        send(b);
        repeat (15) @(negedge clk);
    endtask

    task automatic do_reset();
        re = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (10) @(negedge clk);
        checks++;
        if ({f1, p1, n1, o1} !== 25'd0) begin
            errors++;
            $display("FAIL reset_hold1 got %h want 0", {f1, p1, n1, o1});
        end
        checks++;
        if ({f4, p4, n4, o4} !== 100'd0) begin
            errors++;
            $display("FAIL reset_hold4 got %h want 0", {f4, p4, n4, o4});
        end
        rst_n = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        checks++;
        if ({f1, p1, n1, o1} !== exp1()) begin
            errors++;
            $display("FAIL reset_rel1 got %h want %h", {f1, p1, n1, o1}, exp1());
        end
        checks++;
        if ({f4, p4, n4, o4} !== exp4()) begin
            errors++;
            $display("FAIL reset_rel4 got %h want %h", {f4, p4, n4, o4}, exp4());
        end
    endtask

    task automatic test_single_channel();
        logic [7:0] seq [18] = '{8'h90, 8'h40, 8'h20, 8'h90, 8'h44, 8'h20,
                                 8'h80, 8'h44, 8'h20, 8'h90, 8'h12, 8'h20,
                                 8'h90, 8'h14, 8'h20, 8'h80, 8'h36, 8'h30};
        send_slow(8'h90);
        send_slow(8'h36);
        send(8'h30);
        checks++;
        if ({n1, o1} !== {7'h36, 1'b1}) begin
            errors++;
            $display("FAIL single_note got %h/%b want 36/1", n1, o1);
        end
        @(negedge clk);
        checks++;
        if ({f1, p1} !== {16'd253, 1'b1}) begin
            errors++;
            $display("FAIL single_freq got %0d/%b want 253/1", f1, p1);
        end
        repeat (14) @(negedge clk);
        for (int i = 0; i < 15; i++) send_slow(seq[i]);
        checks++;
        if ({n1, o1, f1} !== {7'h36, 1'b1, 16'd253}) begin
            errors++;
            $display("FAIL single_full got %h/%b/%0d want 36/1/253", n1, o1, f1);
        end
        send_slow(seq[15]);
        send_slow(seq[16]);
        send(seq[17]);
        repeat (2) @(negedge clk);
        checks++;
        if ({o1, p1, f1} !== {1'b0, 1'b0, 16'd253}) begin
            errors++;
            $display("FAIL single_off got %b/%b/%0d want 0/0/253", o1, p1, f1);
        end
        checks++;
        if ({f4, p4, n4, o4} !== exp4()) begin
            errors++;
            $display("FAIL single_dut4 got %h want %h", {f4, p4, n4, o4}, exp4());
        end
    endtask

    task automatic test_four_channel();
        logic [7:0] seq [8] = '{8'h90, 8'h3C, 8'h40, 8'h3E, 8'h40, 8'h40, 8'h40, 8'h90};
        do_reset();
        for (int i = 0; i < 7; i++) send(seq[i]);
        @(negedge clk);
        checks++;
        if ({n4[20:0], o4} !== {7'h40, 7'h3E, 7'h3C, 4'b0111}) begin
            errors++;
            $display("FAIL four_alloc got %h/%b want 403e3c/0111", n4[20:0], o4);
        end
        send(8'h90);
        send(8'h3E);
        send(8'h00);
        checks++;
        if (o4 !== 4'b0101) begin
            errors++;
            $display("FAIL four_vel0 got %b want 0101", o4);
        end
        send(8'h90);
        send(8'h45);
        send(8'h40);
        repeat (2) @(negedge clk);
        checks++;
        if ({n4[13:7], f4[31:16], o4} !== {7'h45, 16'd601, 4'b0111}) begin
            errors++;
            $display("FAIL four_reuse got %h/%0d/%b want 45/601/0111",
                     n4[13:7], f4[31:16], o4);
        end
        checks++;
        if ({f1, p1, n1, o1} !== exp1()) begin
            errors++;
            $display("FAIL four_dut1 got %h want %h", {f1, p1, n1, o1}, exp1());
        end
    endtask

    task automatic test_filtering();
        logic [7:0] seq [16] = '{8'hC0, 8'h05, 8'h90, 8'h30, 8'hF8, 8'h40,
                                 8'hA0, 8'h01, 8'h02, 8'h3C, 8'h40,
                                 8'h90, 8'h00, 8'h40, 8'h7F, 8'h40};
        do_reset();
        for (int i = 0; i < 6; i++) send(seq[i]);
        checks++;
        if ({n4[6:0], o4} !== {7'h30, 4'b0001}) begin
            errors++;
            $display("FAIL filt_rt got %h/%b want 30/0001", n4[6:0], o4);
        end
        for (int i = 6; i < 11; i++) send(seq[i]);
        checks++;
        if (o4 !== 4'b0001) begin
            errors++;
            $display("FAIL filt_skip got %b want 0001", o4);
        end
        for (int i = 11; i < 16; i++) send(seq[i]);
        repeat (2) @(negedge clk);
        checks++;
        if ({f4[31:16], f4[47:32]} !== {16'd11, 16'd17127}) begin
            errors++;
            $display("FAIL filt_table got %0d/%0d want 11/17127",
                     f4[31:16], f4[47:32]);
        end
        checks++;
        if ({f4, p4, n4, o4} !== exp4()) begin
            errors++;
            $display("FAIL filt_model got %h want %h", {f4, p4, n4, o4}, exp4());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            int len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                int r = $urandom_range(0, 11);
                logic [7:0] b;
                if (r < 2) b = 8'h90;
                else if (r == 2) b = 8'h80;
                else if (r == 3) b = 8'($urandom_range('hA0, 'hEF));
                else if (r == 4) b = 8'($urandom_range('hF8, 'hFF));
                else if (r == 5 && $urandom_range(0, 3) == 0)
                    b = 8'($urandom_range('hF0, 'hF7));
                else if ($urandom_range(0, 4) == 0) b = 8'h00;
                else b = 8'($urandom_range('h30, 'h37));
                rd = b;
                re = 1'b1;
                @(negedge clk);
                model_byte(int'(b));
            end
            re = 1'b0;
            repeat (2) @(negedge clk);
            checks++;
            if ({f1, p1, n1, o1} !== exp1()) begin
                errors++;
                $display("FAIL b2b1 chunk %0d got %h want %h", k,
                         {f1, p1, n1, o1}, exp1());
            end
            checks++;
            if ({f4, p4, n4, o4} !== exp4()) begin
                errors++;
                $display("FAIL b2b4 chunk %0d got %h want %h", k,
                         {f4, p4, n4, o4}, exp4());
            end
        end
    endtask

    task automatic test_reset_mid_message();
        do_reset();
        rd = 8'h90;
        re = 1'b1;
        @(negedge clk);
        rd = 8'h3C;
        @(negedge clk);
        re = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h40);
        send(8'h3E);
        send(8'h40);
        repeat (2) @(negedge clk);
        checks++;
        if ({f4, p4, n4, o4} !== 100'd0) begin
            errors++;
            $display("FAIL midrst4 got %h want 0", {f4, p4, n4, o4});
        end
        checks++;
        if ({f1, p1, n1, o1} !== exp1()) begin
            errors++;
            $display("FAIL midrst1 got %h want %h", {f1, p1, n1, o1}, exp1());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_channel();
        test_four_channel();
        test_filtering();
        test_back_to_back();
        test_reset_mid_message();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
